acs_select_update: RTL and testbench
====================================

Name: acs_select_update

Overview:
- Compare-select-update stage of the 4-state (K=3) Viterbi decoder.
- Input is the eight candidate path sums and the overflow flag from the add stage.
- Per state, it selects the surviving predecessor and emits one decision bit per state to the traceback memory.
- It registers and normalises the four path metrics, which feed back to the add stage as m_out0..m_out3. Frame length, error halting and restart are handled here.

Parameters:
- FRAME_LEN, 64: trellis steps per frame; frame_done pulses after the last step.
- NORM_THRESH, 8: normalisation threshold and subtrahend, 5-bit value, 1..15.
- INIT_BIAS, 7: metric loaded into states 1..3 at start; state 0 loads 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a new frame: reload metrics, clear error, go RUN.
- in_valid  in  1  candidate sums and error are valid this cycle.
- p0_0, p2_0, p0_1, p2_1, p1_2, p3_2, p1_3, p3_3  in  5 each  candidate sums; pX_Y = path from state X into state Y.
- error  in  1  add-stage overflow flag (any candidate bit4 set).
- m_out0..m_out3  out  5 each  registered path metrics, states 0..3.
- dec  out  4  decision bits; dec[Y]=1 selects the upper predecessor (2 for Y=0/1, 3 for Y=2/3).
- dec_valid  out  1  one-cycle pulse; dec is valid.
- norm_event  out  1  one-cycle pulse coincident with dec_valid when normalisation was applied.
- step_cnt  out  8  trellis steps accepted in the current frame.
- frame_done  out  1  one-cycle pulse with the dec_valid of step FRAME_LEN.
- err_flag  out  1  sticky overflow indicator.
- busy  out  1  high in RUN.

Behaviour:
- **Reset values:** state IDLE; m_out0=0, m_out1..3=INIT_BIAS; dec=0; dec_valid=0; norm_event=0; step_cnt=0; frame_done=0; err_flag=0; busy=0. Reset overrides all other inputs, including mid-frame.
- **FSM states:** IDLE, RUN, HALT.
  - IDLE: outputs hold; in_valid ignored; start -> RUN.
  - RUN: busy=1; each cycle with in_valid=1 is one trellis step.
  - HALT: entered on error; metrics and outputs frozen; in_valid ignored; only start or reset leaves it.
- **start, any state, priority below reset:** m_out0=0, m_out1..3=INIT_BIAS, step_cnt=0, err_flag=0, next state RUN. An in_valid in the same cycle is dropped, and dec_valid stays 0.
- **Step in RUN, in_valid=1 and error=0, latency 1 cycle:**
  - Per-state select:
    - sel0 = min(p0_0, p2_0), dec[0] = (p2_0 < p0_0).
    - sel1 = min(p0_1, p2_1), dec[1] = (p2_1 < p0_1).
    - sel2 = min(p1_2, p3_2), dec[2] = (p3_2 < p1_2).
    - sel3 = min(p1_3, p3_3), dec[3] = (p3_3 < p1_3).
  - Ties select the lower-numbered predecessor (dec bit 0).
  - Normalisation: if min(sel0..sel3) >= NORM_THRESH, m_outY = selY - NORM_THRESH and norm_event=1; otherwise m_outY = selY.
  - Comparisons are 5-bit unsigned; subtraction never underflows.
  - dec_valid=1 and step_cnt increments.
  - If the step count reaches FRAME_LEN: frame_done=1, next state IDLE, step_cnt holds FRAME_LEN until the next start.
- **Step in RUN, in_valid=1 and error=1:**
  - No metric or dec update; dec_valid=0.
  - err_flag=1 the next cycle; next state HALT.
- **in_valid=0 in RUN:** all registers hold; pulse outputs drop to 0.
- **Pulse outputs:** dec_valid, norm_event and frame_done are never high for more than one cycle per accepted step.
- **step_cnt width:** 8 bits; FRAME_LEN must be <= 255, checked by an elaboration assertion.

Test Plan:
1. **Reset / start:** reset 2 cycles, then start -> m_out=(0,7,7,7), busy=1, step_cnt=0, err_flag=0 one cycle later.
2. **Select with tie:** in_valid with p0_0=3, p2_0=9, p0_1=5, p2_1=5, p1_2=10, p3_2=4, p1_3=6, p3_3=2, error=0 -> next cycle dec=4'b1100, m_out=(3,5,4,2), dec_valid=1, norm_event=0, step_cnt=1.
3. **Normalisation:** all eight candidates = 12 except p2_0=9 -> sel=(9,12,12,12), min 9 >= 8 -> m_out=(1,4,4,4), dec=4'b0001, norm_event=1.
4. **Overflow halt:** error=1 with in_valid mid-frame -> m_out unchanged, dec_valid=0, err_flag=1, busy=0. Further in_valid is ignored. start -> metrics reinit, err_flag=0, busy=1.
5. **Frame end:** FRAME_LEN=4; four valid steps separated by idle cycles -> frame_done pulses only with the 4th dec_valid, step_cnt=4, state IDLE. A 5th in_valid produces no dec_valid.
6. **Priority:**
   - start and in_valid in the same cycle -> no dec_valid, metrics=(0,7,7,7).
   - reset asserted mid-frame -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/acs_select_update.sv
// Compare-select-update stage for a 4-state (K=3) Viterbi decoder.
// Picks the surviving predecessor per state, emits decision bits, keeps the
// normalised path metrics and sequences frames (IDLE / RUN / HALT).

module acs_select_update #(
  parameter int FRAME_LEN   = 64,
  parameter int NORM_THRESH = 8,
  parameter int INIT_BIAS   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [4:0] p0_0,
  input  logic [4:0] p2_0,
  input  logic [4:0] p0_1,
  input  logic [4:0] p2_1,
  input  logic [4:0] p1_2,
  input  logic [4:0] p3_2,
  input  logic [4:0] p1_3,
  input  logic [4:0] p3_3,
  input  logic       error,
  output logic [4:0] m_out0,
  output logic [4:0] m_out1,
  output logic [4:0] m_out2,
  output logic [4:0] m_out3,
  output logic [3:0] dec,
  output logic       dec_valid,
  output logic       norm_event,
  output logic [7:0] step_cnt,
  output logic       frame_done,
  output logic       err_flag,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);
  localparam logic [4:0] NORM_C      = 5'(NORM_THRESH);
  localparam logic [4:0] BIAS_C      = 5'(INIT_BIAS);

  state_t     state_r;
  state_t     state_nxt_s;

  logic [4:0] sel0_s, sel1_s, sel2_s, sel3_s;
  logic [3:0] dec_sel_s;
  logic [4:0] min_sel_s;
  logic       norm_s;
  logic [7:0] step_inc_s;

  logic [4:0] m0_nxt_s, m1_nxt_s, m2_nxt_s, m3_nxt_s;
  logic [3:0] dec_nxt_s;
  logic       dec_valid_nxt_s;
  logic       norm_nxt_s;
  logic [7:0] step_nxt_s;
  logic       frame_done_nxt_s;
  logic       err_nxt_s;

  // Smaller of two 5-bit unsigned metrics.
  function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
    min5 = (b < a) ? b : a;
  endfunction

  // Per-state survivor select; ties keep the lower-numbered predecessor.
  always_comb begin
    dec_sel_s[0] = (p2_0 < p0_0);
    dec_sel_s[1] = (p2_1 < p0_1);
    dec_sel_s[2] = (p3_2 < p1_2);
    dec_sel_s[3] = (p3_3 < p1_3);
    sel0_s       = min5(p0_0, p2_0);
    sel1_s       = min5(p0_1, p2_1);
    sel2_s       = min5(p1_2, p3_2);
    sel3_s       = min5(p1_3, p3_3);
    min_sel_s    = min5(min5(sel0_s, sel1_s), min5(sel2_s, sel3_s));
    norm_s       = (min_sel_s >= NORM_C);
    step_inc_s   = step_cnt + 8'd1;
  end

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_nxt_s      = state_r;
    m0_nxt_s         = m_out0;
    m1_nxt_s         = m_out1;
    m2_nxt_s         = m_out2;
    m3_nxt_s         = m_out3;
    dec_nxt_s        = dec;
    dec_valid_nxt_s  = 1'b0;
    norm_nxt_s       = 1'b0;
    step_nxt_s       = step_cnt;
    frame_done_nxt_s = 1'b0;
    err_nxt_s        = err_flag;
    if (start) begin
      m0_nxt_s    = 5'd0;
      m1_nxt_s    = BIAS_C;
      m2_nxt_s    = BIAS_C;
      m3_nxt_s    = BIAS_C;
      step_nxt_s  = 8'd0;
      err_nxt_s   = 1'b0;
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (in_valid) begin
            if (error) begin
              err_nxt_s   = 1'b1;
              state_nxt_s = ST_HALT;
            end else begin
              if (norm_s) begin
                m0_nxt_s = sel0_s - NORM_C;
                m1_nxt_s = sel1_s - NORM_C;
                m2_nxt_s = sel2_s - NORM_C;
                m3_nxt_s = sel3_s - NORM_C;
              end else begin
                m0_nxt_s = sel0_s;
                m1_nxt_s = sel1_s;
                m2_nxt_s = sel2_s;
                m3_nxt_s = sel3_s;
              end
              norm_nxt_s      = norm_s;
              dec_nxt_s       = dec_sel_s;
              dec_valid_nxt_s = 1'b1;
              step_nxt_s      = step_inc_s;
              if (step_inc_s == FRAME_LEN_C) begin
                frame_done_nxt_s = 1'b1;
                state_nxt_s      = ST_IDLE;
              end else begin
                state_nxt_s = ST_RUN;
              end
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_HALT: state_nxt_s = ST_HALT;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      m_out0     <= 5'd0;
      m_out1     <= BIAS_C;
      m_out2     <= BIAS_C;
      m_out3     <= BIAS_C;
      dec        <= 4'd0;
      dec_valid  <= 1'b0;
      norm_event <= 1'b0;
      step_cnt   <= 8'd0;
      frame_done <= 1'b0;
      err_flag   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      m_out0     <= m0_nxt_s;
      m_out1     <= m1_nxt_s;
      m_out2     <= m2_nxt_s;
      m_out3     <= m3_nxt_s;
      dec        <= dec_nxt_s;
      dec_valid  <= dec_valid_nxt_s;
      norm_event <= norm_nxt_s;
      step_cnt   <= step_nxt_s;
      frame_done <= frame_done_nxt_s;
      err_flag   <= err_nxt_s;
      busy       <= (state_nxt_s == ST_RUN);
    end
  end

  acs_select_update_chk #(
    .FRAME_LEN   (FRAME_LEN),
    .NORM_THRESH (NORM_THRESH)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .norm_event (norm_event),
    .frame_done (frame_done)
  );

endmodule

// Parameter range checks and pulse-relationship properties.
module acs_select_update_chk #(
  parameter int FRAME_LEN   = 64,
  parameter int NORM_THRESH = 8
) (
  input logic clk,
  input logic reset,
  input logic dec_valid,
  input logic norm_event,
  input logic frame_done
);

  // step_cnt is 8 bits wide, so the frame must fit in it.
  if ((FRAME_LEN < 1) || (FRAME_LEN > 255)) begin : g_frame_len_bad
    $error("FRAME_LEN must be in 1..255");
  end

  // Threshold doubles as a 5-bit subtrahend.
  if ((NORM_THRESH < 1) || (NORM_THRESH > 15)) begin : g_norm_bad
    $error("NORM_THRESH must be in 1..15");
  end

  a_norm_with_dec : assert property (@(posedge clk) disable iff (reset)
    norm_event |-> dec_valid);

  a_done_with_dec : assert property (@(posedge clk) disable iff (reset)
    frame_done |-> dec_valid);

endmodule

// File: tb/tb_acs_select_update.sv
// Bench for acs_select_update: directed vector table followed by random
// stimulus checked against a behavioural model of the decoder stage.

module tb_acs_select_update;

  logic       clk;
  logic       reset, start, in_valid, error;
  logic [4:0] p0_0, p2_0, p0_1, p2_1, p1_2, p3_2, p1_3, p3_3;
  logic [4:0] m_out0, m_out1, m_out2, m_out3;
  logic [3:0] dec;
  logic       dec_valid, norm_event, frame_done, err_flag, busy;
  logic [7:0] step_cnt;

  int errors = 0;
  int checks = 0;

  acs_select_update #(.FRAME_LEN(4), .NORM_THRESH(8), .INIT_BIAS(7)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .p0_0(p0_0), .p2_0(p2_0), .p0_1(p0_1), .p2_1(p2_1),
    .p1_2(p1_2), .p3_2(p3_2), .p1_3(p1_3), .p3_3(p3_3),
    .error(error),
    .m_out0(m_out0), .m_out1(m_out1), .m_out2(m_out2), .m_out3(m_out3),
    .dec(dec), .dec_valid(dec_valid), .norm_event(norm_event),
    .step_cnt(step_cnt), .frame_done(frame_done), .err_flag(err_flag),
    .busy(busy)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, iv, er;
    logic [39:0] p;    // candidate i at [5*i +: 5]: p0_0,p2_0,p0_1,p2_1,p1_2,p3_2,p1_3,p3_3
    logic [19:0] m;    // expected metric of state i at [5*i +: 5]
    logic [3:0]  d;
    logic        dv, ne;
    logic [7:0]  sc;
    logic        fd, ef, bz;
  } vec_t;

  vec_t vecs [21];

  // Behavioural model state
  int  md_m [4];
  int  md_dec, md_sc, md_phase;   // phase: 0 idle, 1 running, 2 halted
  bit  md_dv, md_ne, md_fd, md_ef;
  localparam int FL = 4, NT = 8, IB = 7;

  function automatic logic [39:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    pk8 = {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [19:0] pk4(input int e0, e1, e2, e3);
    pk4 = {5'(e3), 5'(e2), 5'(e1), 5'(e0)};
  endfunction

  function automatic vec_t mkv(input logic rst, st, iv, er, input logic [39:0] p,
                               input logic [19:0] m, input logic [3:0] d,
                               input logic dv, ne, input int sc,
                               input logic fd, ef, bz);
    vec_t v;
    v.rst = rst; v.st = st; v.iv = iv; v.er = er; v.p = p; v.m = m; v.d = d;
    v.dv = dv; v.ne = ne; v.sc = 8'(sc); v.fd = fd; v.ef = ef; v.bz = bz;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, iv, er, input logic [39:0] p);
    reset = rst; start = st; in_valid = iv; error = er;
    p0_0 = p[4:0];   p2_0 = p[9:5];   p0_1 = p[14:10]; p2_1 = p[19:15];
    p1_2 = p[24:20]; p3_2 = p[29:25]; p1_3 = p[34:30]; p3_3 = p[39:35];
  endtask

  // Advance the model by one clock using the rules of the stage.
  task automatic model_step(input logic rst, st, iv, er, input logic [39:0] p);
    int lo, up, mn;
    int sel [4];
    md_dv = 1'b0; md_ne = 1'b0; md_fd = 1'b0;
    if (rst) begin
      md_phase = 0; md_m = '{0, IB, IB, IB}; md_dec = 0; md_sc = 0; md_ef = 1'b0;
    end else if (st) begin
      md_phase = 1; md_m = '{0, IB, IB, IB}; md_sc = 0; md_ef = 1'b0;
    end else if (md_phase == 1 && iv) begin
      if (er) begin
        md_ef = 1'b1; md_phase = 2;
      end else begin
        mn = 1000; md_dec = 0;
        for (int y = 0; y < 4; y++) begin
          lo = int'(p[10*y +: 5]);
          up = int'(p[10*y+5 +: 5]);
          if (up < lo) begin sel[y] = up; md_dec += (1 << y); end
          else sel[y] = lo;
          if (sel[y] < mn) mn = sel[y];
        end
        md_ne = (mn >= NT);
        for (int y = 0; y < 4; y++) md_m[y] = md_ne ? sel[y] - NT : sel[y];
        md_dv = 1'b1;
        md_sc++;
        if (md_sc == FL) begin md_fd = 1'b1; md_phase = 0; end
      end
    end
  endtask

  task automatic cycle(input logic rst, st, iv, er, input logic [39:0] p);
    drive(rst, st, iv, er, p);
    @(posedge clk);
    #1;
    model_step(rst, st, iv, er, p);
  endtask

  initial begin
    logic [39:0] pr;
    logic rr, ss, vv, ee;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 40'd0);
    md_phase = 0; md_m = '{0, IB, IB, IB}; md_dec = 0; md_sc = 0; md_ef = 1'b0;

    vecs[0]  = mkv(1,0,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(0,7,7,7), 4'b0000, 0,0, 0, 0,0,0);
    vecs[1]  = mkv(1,0,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(0,7,7,7), 4'b0000, 0,0, 0, 0,0,0);
    vecs[2]  = mkv(0,0,1,0, pk8(1,2,3,4,5,6,7,8),       pk4(0,7,7,7), 4'b0000, 0,0, 0, 0,0,0);
    vecs[3]  = mkv(0,1,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(0,7,7,7), 4'b0000, 0,0, 0, 0,0,1);
    vecs[4]  = mkv(0,0,1,0, pk8(3,9,5,5,10,4,6,2),      pk4(3,5,4,2), 4'b1100, 1,0, 1, 0,0,1);
    vecs[5]  = mkv(0,0,0,0, pk8(1,1,1,1,1,1,1,1),       pk4(3,5,4,2), 4'b1100, 0,0, 1, 0,0,1);
    vecs[6]  = mkv(0,0,1,0, pk8(12,9,12,12,12,12,12,12), pk4(1,4,4,4), 4'b0001, 1,1, 2, 0,0,1);
    vecs[7]  = mkv(0,0,1,1, pk8(0,0,0,0,0,0,0,0),       pk4(1,4,4,4), 4'b0001, 0,0, 2, 0,1,0);
    vecs[8]  = mkv(0,0,1,0, pk8(0,0,0,0,0,0,0,0),       pk4(1,4,4,4), 4'b0001, 0,0, 2, 0,1,0);
    vecs[9]  = mkv(0,1,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(0,7,7,7), 4'b0001, 0,0, 0, 0,0,1);
    vecs[10] = mkv(0,0,1,0, pk8(1,2,3,4,5,6,7,8),       pk4(1,3,5,7), 4'b0000, 1,0, 1, 0,0,1);
    vecs[11] = mkv(0,0,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(1,3,5,7), 4'b0000, 0,0, 1, 0,0,1);
    vecs[12] = mkv(0,0,1,0, pk8(20,8,10,10,9,15,30,12), pk4(0,2,1,4), 4'b1001, 1,1, 2, 0,0,1);
    vecs[13] = mkv(0,0,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(0,2,1,4), 4'b1001, 0,0, 2, 0,0,1);
    vecs[14] = mkv(0,0,1,0, pk8(4,4,4,4,4,4,4,4),       pk4(4,4,4,4), 4'b0000, 1,0, 3, 0,0,1);
    vecs[15] = mkv(0,0,0,0, pk8(0,0,0,0,0,0,0,0),       pk4(4,4,4,4), 4'b0000, 0,0, 3, 0,0,1);
    vecs[16] = mkv(0,0,1,0, pk8(2,1,0,3,7,6,5,5),       pk4(1,0,6,5), 4'b0101, 1,0, 4, 1,0,0);
    vecs[17] = mkv(0,0,1,0, pk8(9,9,9,9,9,9,9,9),       pk4(1,0,6,5), 4'b0101, 0,0, 4, 0,0,0);
    vecs[18] = mkv(0,1,1,0, pk8(0,0,0,0,0,0,0,0),       pk4(0,7,7,7), 4'b0101, 0,0, 0, 0,0,1);
    vecs[19] = mkv(0,0,1,0, pk8(3,9,5,5,10,4,6,2),      pk4(3,5,4,2), 4'b1100, 1,0, 1, 0,0,1);
    vecs[20] = mkv(1,0,1,0, pk8(1,1,1,1,1,1,1,1),       pk4(0,7,7,7), 4'b0000, 0,0, 0, 0,0,0);

    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].rst, vecs[i].st, vecs[i].iv, vecs[i].er, vecs[i].p);
      check($sformatf("v%0d.m0", i), int'(m_out0), int'(vecs[i].m[4:0]));
      check($sformatf("v%0d.m1", i), int'(m_out1), int'(vecs[i].m[9:5]));
      check($sformatf("v%0d.m2", i), int'(m_out2), int'(vecs[i].m[14:10]));
      check($sformatf("v%0d.m3", i), int'(m_out3), int'(vecs[i].m[19:15]));
      check($sformatf("v%0d.dec", i), int'(dec), int'(vecs[i].d));
      check($sformatf("v%0d.dec_valid", i), int'(dec_valid), int'(vecs[i].dv));
      check($sformatf("v%0d.norm_event", i), int'(norm_event), int'(vecs[i].ne));
      check($sformatf("v%0d.step_cnt", i), int'(step_cnt), int'(vecs[i].sc));
      check($sformatf("v%0d.frame_done", i), int'(frame_done), int'(vecs[i].fd));
      check($sformatf("v%0d.err_flag", i), int'(err_flag), int'(vecs[i].ef));
      check($sformatf("v%0d.busy", i), int'(busy), int'(vecs[i].bz));
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(0, 63) == 0);
      ss = ($urandom_range(0, 11) == 0);
      vv = ($urandom_range(0, 2) != 0);
      ee = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 8; k++)
        pr[5*k +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(6, 20));
      cycle(rr, ss, vv, ee, pr);
      check("r.m0", int'(m_out0), md_m[0]);
      check("r.m1", int'(m_out1), md_m[1]);
      check("r.m2", int'(m_out2), md_m[2]);
      check("r.m3", int'(m_out3), md_m[3]);
      check("r.dec", int'(dec), md_dec);
      check("r.dec_valid", int'(dec_valid), int'(md_dv));
      check("r.norm_event", int'(norm_event), int'(md_ne));
      check("r.step_cnt", int'(step_cnt), md_sc);
      check("r.frame_done", int'(frame_done), int'(md_fd));
      check("r.err_flag", int'(err_flag), int'(md_ef));
      check("r.busy", int'(busy), int'(md_phase == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
